axi_fault_capture: RTL and testbench
====================================

Name: axi_fault_capture

Overview:
- Passive AXI4 bus observer, fed by the same master-side AW/AR/R/B taps as the access-fault monitor.
- Consumes the SLVERR/DECERR responses the monitor flags.
- Resolves each faulting response back to its request address, since the R/B channels carry no address.
- Holds a single fault record with a valid/ack handshake for the trap/CSR logic (mtval source), plus a saturating fault counter and a sticky protocol-error flag.

Parameters:
- AW, 32, address width (matches CPU_WIDTH)
- IDW, 4, AXI ID width
- DEPTH, 4, outstanding requests tracked per direction (power of 2, >=2)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- awvalid, awready  in  1  AW handshake
- awaddr  in  AW  write address
- awid  in  IDW  write ID
- arvalid, arready  in  1  AR handshake
- araddr  in  AW  read address
- arid  in  IDW  read ID
- rvalid, rready, rlast  in  1  R handshake / last beat
- rresp  in  2  read response
- rid  in  IDW  read ID
- bvalid, bready  in  1  B handshake
- bresp  in  2  write response
- bid  in  IDW  write ID
- fault_ack  in  1  consumer releases record
- fault_valid  out  1  record held
- fault_is_write  out  1  1 = B fault, 0 = R fault
- fault_addr  out  AW  request address of faulting transaction
- fault_id  out  IDW  response ID
- fault_resp  out  2  captured resp code
- fault_beat  out  8  R beat index within burst (0 for B)
- fault_count  out  8  saturating count of faulting beats/responses
- proto_err  out  1  sticky: tracker overflow/underflow or ID mismatch

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, both trackers empty, beat counter 0. Mid-burst reset discards all tracking.
- Handshake definitions: AR fire = arvalid&arready; AW fire = awvalid&awready; R fire = rvalid&rready; B fire = bvalid&bready.
- Read tracker: in-order FIFO of {arid, araddr}, DEPTH entries. Push on AR fire; pop on R fire with rlast.
- Write tracker: same structure, {awid, awaddr}. Push on AW fire; pop on B fire.
- Simultaneous push and pop are legal at any occupancy, including full and empty-with-push (the pop then reports head = entry pushed in an earlier cycle only).
- Push when full without a pop: the push is dropped and proto_err is set.
- R or B fire with the tracker empty: proto_err is set; a fault taken here captures addr 0.
- Response ID differs from the head entry's ID: proto_err is set; the head is still used and popped.
- R beat counter: 8-bit; increments on each R fire without rlast; clears on R fire with rlast; wraps at 255.
- A fault event is R fire with rresp != 0, or B fire with bresp != 0.
- fault_count: adds the number of fault events each cycle (0, 1 or 2); saturates at 255.
- Capture condition: a fault event occurs and (fault_valid=0 or fault_ack=1).
  - Record registers on the next edge; fault_valid=1 the same edge (1-cycle latency).
  - Record fields: head addr, response ID, resp, beat index (current counter value for R, 0 for B), is_write.
- Simultaneous R and B faults: the R fault is captured; both are counted.
- fault_ack=1 with no new fault: fault_valid=0 next edge; record fields hold their old values.
- fault_ack=1 while fault_valid=0 has no effect.
- While fault_valid=1 and no ack: new faults are counted only; the record is frozen (first-fault wins).
- proto_err and fault_count clear only on reset.
- W channel is not observed.

Decomposition:
- Shared package (axi_pkg), holding:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - burst/size constants
  - the fault_record struct typedef {is_write, addr, id, resp, beat}
- One sub-module, axi_req_tracker: parameterised sync FIFO (width AW+IDW, DEPTH).
  - Inputs: push, pop. Outputs: head data, full, empty.
  - Instantiated twice, once per direction.

Test Plan:
- AR id=2 addr=0x8000_0010 len=3; 4 R beats OKAY except beat 2 SLVERR -> fault_valid=1 one cycle after beat 2 handshake; fault_addr=0x8000_0010, fault_beat=2, resp=2'b10, is_write=0, fault_count=1.
- AW id=1 addr=0xA000_0000, B DECERR; hold without ack; then a second read fault -> record stays the write fault; fault_count=2; ack -> fault_valid=0 next cycle.
- R SLVERR and B DECERR in the same cycle with the record empty -> read fault captured; fault_count += 2.
- fault_ack asserted in the same cycle as a new B SLVERR -> fault_valid stays 1 with the new record (is_write=1).
- Five ARs without responses (DEPTH=4) -> proto_err=1 after the fifth push. After reset: B fire with empty tracker -> proto_err=1; an error response there gives fault_addr=0.
- 300 faulting R beats -> fault_count saturates at 255. Assert i_rst_n mid-burst -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the fault record layout used by the fault-capture block.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  typedef struct packed {
    logic                  is_write;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [7:0]            beat;
  } fault_record_t;

endpackage

// File: rtl/axi_req_tracker.sv
// In-order request tracker: small sync FIFO holding {id, addr} of outstanding requests.
module axi_req_tracker #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  // A pop frees a slot for a same-cycle push when full; an empty FIFO cannot pop
  // the entry being pushed this cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_fault_capture.sv
// Passive AXI4 observer: maps SLVERR/DECERR responses back to their request address
// and holds one fault record (valid/ack), a saturating fault count and a sticky protocol error.
module axi_fault_capture
  import axi_pkg::*;
#(
  parameter int unsigned AW    = AXI_ADDR_W,
  parameter int unsigned IDW   = AXI_ID_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           awvalid,
  input  logic           awready,
  input  logic [AW-1:0]  awaddr,
  input  logic [IDW-1:0] awid,
  input  logic           arvalid,
  input  logic           arready,
  input  logic [AW-1:0]  araddr,
  input  logic [IDW-1:0] arid,
  input  logic           rvalid,
  input  logic           rready,
  input  logic           rlast,
  input  logic [1:0]     rresp,
  input  logic [IDW-1:0] rid,
  input  logic           bvalid,
  input  logic           bready,
  input  logic [1:0]     bresp,
  input  logic [IDW-1:0] bid,
  input  logic           fault_ack,
  output logic           fault_valid,
  output logic           fault_is_write,
  output logic [AW-1:0]  fault_addr,
  output logic [IDW-1:0] fault_id,
  output logic [1:0]     fault_resp,
  output logic [7:0]     fault_beat,
  output logic [7:0]     fault_count,
  output logic           proto_err
);

  localparam int unsigned TW = AW + IDW;

  logic          ar_fire, aw_fire, r_fire, b_fire;
  logic [TW-1:0] r_head, w_head;
  logic          r_full, r_empty, w_full, w_empty;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_fault, b_fault, capture, perr_set;
  logic [8:0]    count_sum;
  logic [7:0]    count_next;
  logic [7:0]    beat_cnt;
  logic          rec_valid;
  fault_record_t rec, rec_next;

  assign ar_fire = arvalid & arready;
  assign aw_fire = awvalid & awready;
  assign r_fire  = rvalid & rready;
  assign b_fire  = bvalid & bready;

  axi_req_tracker #(.W(TW), .DEPTH(DEPTH)) u_rd_trk (
    .clk(i_clk), .rst_n(i_rst_n),
    .push(ar_fire), .pop(r_fire & rlast), .din({arid, araddr}),
    .head(r_head), .full(r_full), .empty(r_empty)
  );

  axi_req_tracker #(.W(TW), .DEPTH(DEPTH)) u_wr_trk (
    .clk(i_clk), .rst_n(i_rst_n),
    .push(aw_fire), .pop(b_fire), .din({awid, awaddr}),
    .head(w_head), .full(w_full), .empty(w_empty)
  );

  always_comb begin
    r_addr   = r_empty ? '0 : r_head[AW-1:0];
    w_addr   = w_empty ? '0 : w_head[AW-1:0];
    perr_set = (ar_fire & r_full & ~(r_fire & rlast))
             | (aw_fire & w_full & ~b_fire)
             | (r_fire & r_empty)
             | (b_fire & w_empty)
             | (r_fire & ~r_empty & (r_head[TW-1:AW] != rid))
             | (b_fire & ~w_empty & (w_head[TW-1:AW] != bid));
    r_fault  = r_fire & (rresp != AXI_RESP_OKAY);
    b_fault  = b_fire & (bresp != AXI_RESP_OKAY);
    capture  = (r_fault | b_fault) & (~rec_valid | fault_ack);

    count_sum  = {1'b0, fault_count} + 9'(r_fault) + 9'(b_fault);
    count_next = count_sum[8] ? '1 : count_sum[7:0];

    // Read fault takes priority when both channels fault in the same cycle.
    rec_next = '0;
    if (r_fault) begin
      rec_next.is_write = 1'b0;
      rec_next.addr     = r_addr;
      rec_next.id       = rid;
      rec_next.resp     = rresp;
      rec_next.beat     = beat_cnt;
    end else begin
      rec_next.is_write = 1'b1;
      rec_next.addr     = w_addr;
      rec_next.id       = bid;
      rec_next.resp     = bresp;
      rec_next.beat     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_valid   <= 1'b0;
      rec         <= '0;
      beat_cnt    <= '0;
      fault_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      fault_count <= count_next;
      if (perr_set) proto_err <= 1'b1;
      if (r_fire) beat_cnt <= rlast ? '0 : beat_cnt + 1'b1;
      if (capture) begin
        rec_valid <= 1'b1;
        rec       <= rec_next;
      end else if (fault_ack) begin
        rec_valid <= 1'b0;
      end
    end
  end

  assign fault_valid    = rec_valid;
  assign fault_is_write = rec.is_write;
  assign fault_addr     = rec.addr;
  assign fault_id       = rec.id;
  assign fault_resp     = rec.resp;
  assign fault_beat     = rec.beat;

endmodule

// File: tb/tb_axi_fault_capture.sv
// Bench for axi_fault_capture: directed scenarios plus randomized traffic against a
// queue-based reference model of the request/response bookkeeping.
module tb_axi_fault_capture;

  localparam int unsigned DEPTH = 4;

  logic        i_clk, i_rst_n;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, rid, bid;
  logic        rvalid, rready, rlast, bvalid, bready, fault_ack;
  logic [1:0]  rresp, bresp;
  logic        fault_valid, fault_is_write, proto_err;
  logic [31:0] fault_addr;
  logic [3:0]  fault_id;
  logic [1:0]  fault_resp;
  logic [7:0]  fault_beat, fault_count;

  axi_fault_capture #(.AW(32), .IDW(4), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rid(rid),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .fault_ack(fault_ack), .fault_valid(fault_valid), .fault_is_write(fault_is_write),
    .fault_addr(fault_addr), .fault_id(fault_id), .fault_resp(fault_resp),
    .fault_beat(fault_beat), .fault_count(fault_count), .proto_err(proto_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } req_t;

  req_t        rq[$], wq[$];
  int          m_beat, m_count;
  logic        m_valid, m_is_write, m_perr;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [1:0]  m_resp;
  logic [7:0]  m_rec_beat;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete(); wq.delete();
    m_beat = 0; m_count = 0;
    m_valid = 0; m_is_write = 0; m_perr = 0;
    m_addr = '0; m_id = '0; m_resp = '0; m_rec_beat = '0;
  endtask

  task automatic check_all();
    chk("valid", 64'(fault_valid), 64'(m_valid));
    chk("is_write", 64'(fault_is_write), 64'(m_is_write));
    chk("addr", 64'(fault_addr), 64'(m_addr));
    chk("id", 64'(fault_id), 64'(m_id));
    chk("resp", 64'(fault_resp), 64'(m_resp));
    chk("beat", 64'(fault_beat), 64'(m_rec_beat));
    chk("count", 64'(fault_count), 64'(m_count));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
  endtask

  // Applies the observation rules to the inputs currently on the bus.
  task automatic model_step();
    bit          rf, bf, r_flt, b_flt, rpop, bpop;
    logic [31:0] ra, wa;
    int          rsz, wsz;
    rf  = rvalid && rready;
    bf  = bvalid && bready;
    rsz = rq.size();
    wsz = wq.size();
    ra  = 0;
    wa  = 0;
    if (rf) begin
      if (rsz == 0) m_perr = 1;
      else begin
        ra = rq[0].addr;
        if (rq[0].id != rid) m_perr = 1;
      end
    end
    if (bf) begin
      if (wsz == 0) m_perr = 1;
      else begin
        wa = wq[0].addr;
        if (wq[0].id != bid) m_perr = 1;
      end
    end
    r_flt = rf && (rresp != 0);
    b_flt = bf && (bresp != 0);
    m_count = m_count + int'(r_flt) + int'(b_flt);
    if (m_count > 255) m_count = 255;
    if ((r_flt || b_flt) && (!m_valid || fault_ack)) begin
      m_valid = 1;
      if (r_flt) begin
        m_is_write = 0; m_addr = ra; m_id = rid; m_resp = rresp; m_rec_beat = 8'(m_beat);
      end else begin
        m_is_write = 1; m_addr = wa; m_id = bid; m_resp = bresp; m_rec_beat = 0;
      end
    end else if (fault_ack) m_valid = 0;
    if (rf) m_beat = rlast ? 0 : (m_beat + 1) % 256;
    rpop = rf && rlast && rsz > 0;
    bpop = bf && wsz > 0;
    if (rpop) void'(rq.pop_front());
    if (bpop) void'(wq.pop_front());
    if (arvalid && arready) begin
      if (rsz < DEPTH || rpop) rq.push_back('{arid, araddr});
      else m_perr = 1;
    end
    if (awvalid && awready) begin
      if (wsz < DEPTH || bpop) wq.push_back('{awid, awaddr});
      else m_perr = 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    awvalid = 0; awready = 1; awaddr = '0; awid = '0;
    arvalid = 0; arready = 1; araddr = '0; arid = '0;
    rvalid = 0; rready = 1; rlast = 0; rresp = '0; rid = '0;
    bvalid = 0; bready = 1; bresp = '0; bid = '0;
    fault_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 0;
    model_reset();
    #2;
    check_all();
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] a);
    idle(); arvalid = 1; arid = id; araddr = a; cycle();
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a);
    idle(); awvalid = 1; awid = id; awaddr = a; cycle();
  endtask

  task automatic rbeat(input logic [3:0] id, input logic [1:0] resp, input logic last);
    idle(); rvalid = 1; rid = id; rresp = resp; rlast = last; cycle();
  endtask

  initial begin
    i_rst_n = 1;
    idle();
    model_reset();
    #1;
    do_reset();
    chk("reset_valid", 64'(fault_valid), 64'd0);

    // Read burst with SLVERR on beat 2
    ar(4'd2, 32'h8000_0010);
    rbeat(4'd2, 2'b00, 0);
    rbeat(4'd2, 2'b00, 0);
    chk("t1_valid_early", 64'(fault_valid), 64'd0);
    rbeat(4'd2, 2'b10, 0);
    chk("t1_valid", 64'(fault_valid), 64'd1);
    chk("t1_addr", 64'(fault_addr), 64'h8000_0010);
    chk("t1_beat", 64'(fault_beat), 64'd2);
    chk("t1_resp", 64'(fault_resp), 64'd2);
    chk("t1_is_write", 64'(fault_is_write), 64'd0);
    chk("t1_count", 64'(fault_count), 64'd1);
    rbeat(4'd2, 2'b00, 1);

    // Write DECERR held, then a read fault that must not overwrite it
    do_reset();
    aw(4'd1, 32'hA000_0000);
    idle(); bvalid = 1; bid = 4'd1; bresp = 2'b11; cycle();
    ar(4'd3, 32'h0000_1000);
    rbeat(4'd3, 2'b10, 1);
    chk("t2_is_write", 64'(fault_is_write), 64'd1);
    chk("t2_addr", 64'(fault_addr), 64'hA000_0000);
    chk("t2_count", 64'(fault_count), 64'd2);
    idle(); fault_ack = 1; cycle();
    chk("t2_ack", 64'(fault_valid), 64'd0);
    idle(); fault_ack = 1; cycle();

    // Simultaneous R and B faults, then ack racing a new B fault
    do_reset();
    idle(); arvalid = 1; arid = 4'd4; araddr = 32'h0000_4440;
    awvalid = 1; awid = 4'd5; awaddr = 32'h0000_5550; cycle();
    idle(); rvalid = 1; rid = 4'd4; rresp = 2'b10; rlast = 1;
    bvalid = 1; bid = 4'd5; bresp = 2'b11; cycle();
    chk("t3_is_write", 64'(fault_is_write), 64'd0);
    chk("t3_addr", 64'(fault_addr), 64'h0000_4440);
    chk("t3_count", 64'(fault_count), 64'd2);
    aw(4'd6, 32'h0000_6660);
    idle(); bvalid = 1; bid = 4'd6; bresp = 2'b10; fault_ack = 1; cycle();
    chk("t4_valid", 64'(fault_valid), 64'd1);
    chk("t4_is_write", 64'(fault_is_write), 64'd1);
    chk("t4_addr", 64'(fault_addr), 64'h0000_6660);

    // Tracker overflow, then underflow with an error response
    do_reset();
    for (int unsigned i = 0; i < 4; i++) ar(4'(i), 32'h100 * i);
    chk("t5_no_perr", 64'(proto_err), 64'd0);
    ar(4'd7, 32'h0000_0700);
    chk("t5_overflow", 64'(proto_err), 64'd1);
    do_reset();
    idle(); bvalid = 1; bid = 4'd0; bresp = 2'b11; cycle();
    chk("t5_underflow", 64'(proto_err), 64'd1);
    chk("t5_addr0", 64'(fault_addr), 64'd0);

    // Count saturation across a long faulting burst, then async reset mid-burst
    do_reset();
    ar(4'd9, 32'h0000_0040);
    for (int unsigned i = 0; i < 300; i++) begin
      idle(); rvalid = 1; rid = 4'd9; rresp = 2'b10; fault_ack = 1; cycle();
    end
    chk("t6_sat", 64'(fault_count), 64'd255);
    idle(); rvalid = 1; rid = 4'd9; rresp = 2'b00;
    #2;
    i_rst_n = 0;
    #1;
    chk("t6_async_valid", 64'(fault_valid), 64'd0);
    chk("t6_async_count", 64'(fault_count), 64'd0);
    chk("t6_async_addr", 64'(fault_addr), 64'd0);
    chk("t6_async_perr", 64'(proto_err), 64'd0);
    do_reset();

    // Randomized well-formed traffic
    for (int unsigned i = 0; i < 600; i++) begin
      idle();
      arvalid = ($urandom_range(0, 2) == 0) && (rq.size() < DEPTH);
      arready = 1'($urandom_range(0, 1));
      araddr  = $urandom;
      arid    = 4'($urandom);
      awvalid = ($urandom_range(0, 2) == 0) && (wq.size() < DEPTH);
      awready = 1'($urandom_range(0, 1));
      awaddr  = $urandom;
      awid    = 4'($urandom);
      if (rq.size() > 0) begin
        rvalid = 1'($urandom_range(0, 1));
        rready = ($urandom_range(0, 3) != 0);
        rid    = rq[0].id;
        rlast  = ($urandom_range(0, 2) == 0);
        rresp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      if (wq.size() > 0) begin
        bvalid = 1'($urandom_range(0, 1));
        bready = ($urandom_range(0, 3) != 0);
        bid    = wq[0].id;
        bresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      fault_ack = ($urandom_range(0, 3) == 0);
      cycle();
    end
    chk("rand_no_perr", 64'(proto_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
